mult_div_unit: RTL

Multiply/divide unit for the pipelined MIPS core: the responder on the E-stage Start/Busy handshake that the hazard unit consumes to stall `mult/multu/div/divu/mfhi/mflo/mthi/mtlo`. It accepts an operation and two operands in E, holds Busy for a fixed latency, then commits HI/LO. The core reads HI/LO combinationally for `mfhi/mflo`.

---
 rtl/mdu_defs_pkg.sv | 38 +++
 rtl/mdu_arith.sv | 89 ++++++++
 rtl/mult_div_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mdu_defs_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the Op encodings, default latencies, FSM state type and the
// {hi,lo} result payload shared by mdu_arith and mult_div_unit.
package mdu_defs_pkg;

    localparam int unsigned MDU_OP_W  = 3;
    localparam int unsigned MDU_DAT_W = 32;

    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd1;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd3;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd5;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [MDU_DAT_W-1:0] hi;
        logic [MDU_DAT_W-1:0] lo;
    } mdu_result_t;

    // True for the ops that occupy the unit (mult/multu/div/divu)
    function automatic logic mdu_is_long_op(input logic [MDU_OP_W-1:0] op);
        return (op <= MDU_DIVU);
    endfunction

    function automatic logic mdu_is_div(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   op          in   operation code (only 0..3 produce a result)
//   a, b        in   rs / rt operands
//   res         out  {hi,lo} result: product, or {remainder,quotient}
//   div_by_zero out  divide op with b == 0; res is then meaningless
module mdu_arith
    import mdu_defs_pkg::*;
(
    input  logic [MDU_OP_W-1:0]  op,
    input  logic [MDU_DAT_W-1:0] a,
    input  logic [MDU_DAT_W-1:0] b,
    output mdu_result_t          res,
    output logic                 div_by_zero
);

    localparam int unsigned W2 = 2 * MDU_DAT_W;

    logic                 a_neg;
    logic                 b_neg;
    logic [MDU_DAT_W-1:0] a_mag;
    logic [MDU_DAT_W-1:0] b_mag;
    logic [MDU_DAT_W-1:0] dvd;
    logic [MDU_DAT_W-1:0] dvs;
    logic [MDU_DAT_W-1:0] uq;
    logic [MDU_DAT_W-1:0] ur;
    logic [W2-1:0]        a_ext;
    logic [W2-1:0]        b_ext;
    logic [W2-1:0]        prod;
    logic                 signed_op;
    logic                 div_ovf;

    // Signed ops work on magnitudes through one unsigned multiplier/divider
    always_comb begin
        signed_op = (op == MDU_MULT) || (op == MDU_DIV);
        a_neg     = signed_op & a[MDU_DAT_W-1];
        b_neg     = signed_op & b[MDU_DAT_W-1];
        a_mag     = a_neg ? MDU_DAT_W'(~a + 1'b1) : a;
        b_mag     = b_neg ? MDU_DAT_W'(~b + 1'b1) : b;

        // Sign-extended 64-bit operands give the signed product in the low 64 bits
        a_ext = (op == MDU_MULT) ? {{MDU_DAT_W{a[MDU_DAT_W-1]}}, a} : {{MDU_DAT_W{1'b0}}, a};
        b_ext = (op == MDU_MULT) ? {{MDU_DAT_W{b[MDU_DAT_W-1]}}, b} : {{MDU_DAT_W{1'b0}}, b};
        prod  = W2'(a_ext * b_ext);

        // Divisor forced non-zero so the divider never produces X
        dvd = a_mag;
        dvs = (b_mag == '0) ? MDU_DAT_W'(1) : b_mag;
        uq  = dvd / dvs;
        ur  = dvd % dvs;
    end

    // Result select, including the explicit most-negative / -1 case
    always_comb begin
        res         = '0;
        div_by_zero = 1'b0;
        div_ovf     = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MDU_MULT, MDU_MULTU: begin
                res.hi = prod[W2-1:MDU_DAT_W];
                res.lo = prod[MDU_DAT_W-1:0];
            end
            MDU_DIV: begin
                if (b == '0) begin
                    div_by_zero = 1'b1;
                end else if (div_ovf) begin
                    res.hi = '0;
                    res.lo = 32'h8000_0000;
                end else begin
                    res.lo = (a_neg ^ b_neg) ? MDU_DAT_W'(~uq + 1'b1) : uq;
                    res.hi = a_neg ? MDU_DAT_W'(~ur + 1'b1) : ur;
                end
            end
            MDU_DIVU: begin
                if (b == '0) begin
                    div_by_zero = 1'b1;
                end else begin
                    res.lo = uq;
                    res.hi = ur;
                end
            end
            default: begin
                res         = '0;
                div_by_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit: E-stage Start/Busy responder owning HI/LO.
// Accepts mult/multu/div/divu, holds Busy for a fixed latency, then
// commits the pending result; mthi/mtlo write HI/LO directly when idle.
// Optional build macro MDU_CHECK_EN adds simulation-only $error checks.
// Ports:
//   Clk, Reset      clock, asynchronous active-low reset
//   En, Op, A, B    E-stage MD op request and forwarded operands
//   RdSel           0 -> LO, 1 -> HI on Out
//   Start           combinational En & (Op <= 3) to the hazard unit
//   Busy            operation in flight
//   Out             combinational RdSel ? HI : LO
//   HI, LO          architectural registers
module mult_div_unit
    import mdu_defs_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 En,
    input  logic [MDU_OP_W-1:0]  Op,
    input  logic [MDU_DAT_W-1:0] A,
    input  logic [MDU_DAT_W-1:0] B,
    input  logic                 RdSel,
    output logic                 Start,
    output logic                 Busy,
    output logic [MDU_DAT_W-1:0] Out,
    output logic [MDU_DAT_W-1:0] HI,
    output logic [MDU_DAT_W-1:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    mdu_result_t          pend_q, pend_d;
    logic                 keep_q, keep_d;
    logic [MDU_DAT_W-1:0] hi_q, hi_d;
    logic [MDU_DAT_W-1:0] lo_q, lo_d;

    mdu_result_t          arith_res;
    logic                 arith_dz;

    mdu_arith u_arith (
        .op          (Op),
        .a           (A),
        .b           (B),
        .res         (arith_res),
        .div_by_zero (arith_dz)
    );

    assign Start = En & mdu_is_long_op(Op);
    assign Busy  = (state_q == ST_BUSY);
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign Out   = RdSel ? hi_q : lo_q;

    // State, counter, pending result and HI/LO registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            keep_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            keep_q  <= keep_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state: launch when idle, count down when busy, commit on the last edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        keep_d  = keep_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    pend_d  = arith_res;
                    keep_d  = arith_dz;
                    cnt_d   = mdu_is_div(Op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d = ST_BUSY;
                end else if (En && (Op == MDU_MTHI)) begin
                    hi_d = A;
                end else if (En && (Op == MDU_MTLO)) begin
                    lo_d = A;
                end
            end
            ST_BUSY: begin
                // Requests are ignored here; the core stalls on Busy
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    // Divide by zero leaves HI/LO untouched
                    if (!keep_q) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef MDU_CHECK_EN
    // Simulation-only protocol checks
    always @(posedge Clk) begin
        if (Reset) begin
            if (En && Busy)
                $error("mult_div_unit: En asserted while Busy");
            if (En && $isunknown(Op))
                $error("mult_div_unit: Op has X/Z while En");
            else if (En && (Op > MDU_MTLO))
                $error("mult_div_unit: reserved Op %0d with En", Op);
        end
    end
`endif

endmodule
